// File: rtl/ctrace_row_mac.sv
// Per-row camera-trace projector: classifies a raster-ordered sample stream against
// one FSP row window and accumulates weighted samples per camera with saturation.
module ctrace_row_mac #(
  parameter int DELAY        = 1,
  parameter int N_CAM        = 2,
  parameter int FSP_WIDTH    = 6,
  parameter int FSP_ROW      = 1,
  parameter int CAM_ROW_SIZE = 12,
  parameter int CAM_COL_SIZE = 12,
  parameter int CT_W         = 16,
  parameter int FSP_W        = 12,
  parameter int ACC_W        = 24,
  localparam int HIT_W       = $clog2(FSP_WIDTH + 1)
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              init,
  input  logic [CAM_ROW_SIZE-1:0]           config_row,
  input  logic [CAM_COL_SIZE-1:0]           config_col,
  input  logic [ACC_W-1:0]                  config_initial,
  input  logic                              ctrace_valid,
  input  logic [CAM_ROW_SIZE-1:0]           ctrace_row,
  input  logic [CAM_COL_SIZE-1:0]           ctrace_col,
  input  logic [N_CAM*CT_W-1:0]             ctrace,
  input  logic [N_CAM*FSP_WIDTH*FSP_W-1:0]  fsp,
  input  logic                              flush,
  input  logic                              sum_ack,
  output logic                              available,
  output logic                              done,
  output logic [N_CAM*ACC_W-1:0]            result,
  output logic [N_CAM-1:0]                  ovf,
  output logic [HIT_W-1:0]                  n_hits
);

  localparam int PROD_W = CT_W + FSP_W + 1;
  localparam int P_W    = CT_W + 1;
  localparam logic signed [ACC_W-1:0]      ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]      ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [CAM_COL_SIZE:0] WIN_W   = (CAM_COL_SIZE+1)'(FSP_WIDTH);

  // Registered assignments carry no delay in the synthesizable model.
  if (DELAY < 0) begin : g_delay_unused
  end

  typedef enum logic [1:0] {S_FREE, S_COLLECTING, S_FINISHING, S_DONE} state_e;

  state_e                      state_q, state_d;
  logic [CAM_ROW_SIZE-1:0]     me_row_q, me_row_d;
  logic [CAM_COL_SIZE-1:0]     me_col_q, me_col_d;
  logic                        s1_valid_q, s1_valid_d;
  logic                        drain_q, drain_d;
  logic [HIT_W-1:0]            n_hits_q, n_hits_d;
  logic [N_CAM-1:0]            ovf_q, ovf_d;
  logic signed [P_W-1:0]       p_q [N_CAM];
  logic signed [P_W-1:0]       p_d [N_CAM];
  logic signed [ACC_W-1:0]     acc_q [N_CAM];
  logic signed [ACC_W-1:0]     acc_d [N_CAM];
  logic signed [ACC_W-1:0]     result_q [N_CAM];
  logic signed [ACC_W-1:0]     result_d [N_CAM];

  logic [CAM_ROW_SIZE-1:0]     pr;
  logic signed [CAM_COL_SIZE:0] d;
  logic                        row_eq, row_gt, in_win, sample_ok;
  logic                        hit, after, last_col, load, finish;
  int                          col_idx;
  logic signed [PROD_W-1:0]    prod [N_CAM];
  logic signed [ACC_W:0]       sum  [N_CAM];
  logic                        clamp [N_CAM];
  logic signed [ACC_W-1:0]     sat  [N_CAM];

  // Sample classification relative to the window ending at (me_row, me_col).
  always_comb begin
    pr        = ctrace_row + CAM_ROW_SIZE'(FSP_ROW);
    d         = $signed({1'b0, me_col_q}) - $signed({1'b0, ctrace_col});
    row_eq    = (pr == me_row_q);
    row_gt    = (pr > me_row_q);
    in_win    = !d[CAM_COL_SIZE] && (d < WIN_W);
    sample_ok = ctrace_valid && (state_q == S_COLLECTING);
    hit       = sample_ok && row_eq && in_win;
    after     = sample_ok && (row_gt || (row_eq && d[CAM_COL_SIZE]));
    last_col  = hit && (d == '0);
    col_idx   = hit ? int'(d) : 0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_FREE;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb starts from a full default so no path can leave a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FREE:       if (init) state_d = S_COLLECTING;
      S_COLLECTING: if (flush || last_col || after) state_d = S_FINISHING;
      S_FINISHING:  if (drain_q && !s1_valid_q) state_d = S_DONE;
      S_DONE:       if (sum_ack) state_d = S_FREE;
      default:      state_d = S_FREE;
    endcase
  end

  always_comb begin
    available = (state_q == S_FREE);
    done      = (state_q == S_DONE);
    ovf       = ovf_q;
    n_hits    = n_hits_q;
    result    = '0;
    for (int c = 0; c < N_CAM; c++) result[c*ACC_W +: ACC_W] = result_q[c];
  end

  // Two-stage MAC; FINISHING always lasts two cycles so done latency is fixed.
  always_comb begin
    load       = (state_q == S_FREE) && init;
    finish     = (state_q == S_FINISHING) && (state_d == S_DONE);
    me_row_d   = load ? config_row : me_row_q;
    me_col_d   = load ? config_col : me_col_q;
    s1_valid_d = hit;
    drain_d    = (state_q == S_FINISHING);
    n_hits_d   = n_hits_q;
    if (load) n_hits_d = '0;
    else if (hit && (n_hits_q < HIT_W'(FSP_WIDTH))) n_hits_d = n_hits_q + HIT_W'(1);
    ovf_d = load ? '0 : ovf_q;
    for (int c = 0; c < N_CAM; c++) begin
      prod[c]  = PROD_W'($signed(ctrace[c*CT_W +: CT_W]))
               * PROD_W'($signed({1'b0, fsp[(c*FSP_WIDTH + col_idx)*FSP_W +: FSP_W]}));
      p_d[c]   = P_W'(prod[c] >>> FSP_W);
      sum[c]   = (ACC_W+1)'(acc_q[c]) + (ACC_W+1)'(p_q[c]);
      clamp[c] = (sum[c][ACC_W] != sum[c][ACC_W-1]);
      sat[c]   = clamp[c] ? (sum[c][ACC_W] ? ACC_MIN : ACC_MAX) : sum[c][ACC_W-1:0];
      acc_d[c] = acc_q[c];
      if (load) acc_d[c] = config_initial;
      else if (s1_valid_q) begin
        acc_d[c] = sat[c];
        ovf_d[c] = ovf_q[c] | clamp[c];
      end
      result_d[c] = finish ? acc_q[c] : result_q[c];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      me_row_q   <= '0;
      me_col_q   <= '0;
      s1_valid_q <= 1'b0;
      drain_q    <= 1'b0;
      n_hits_q   <= '0;
      ovf_q      <= '0;
      for (int c = 0; c < N_CAM; c++) begin
        acc_q[c]    <= '0;
        result_q[c] <= '0;
      end
    end else begin
      me_row_q   <= me_row_d;
      me_col_q   <= me_col_d;
      s1_valid_q <= s1_valid_d;
      drain_q    <= drain_d;
      n_hits_q   <= n_hits_d;
      ovf_q      <= ovf_d;
      for (int c = 0; c < N_CAM; c++) begin
        acc_q[c]    <= acc_d[c];
        result_q[c] <= result_d[c];
      end
    end
  end

  // NOTE: the product register is left unreset; it is only consumed when s1_valid_q is set.
  always_ff @(posedge CLK) begin
    for (int c = 0; c < N_CAM; c++) p_q[c] <= p_d[c];
  end

endmodule

// File: tb/tb_ctrace_row_mac.sv
// Scoreboard bench for ctrace_row_mac: stimulus pushes expected results, a monitor
// compares them when done rises, including the fixed 3-cycle done latency.
module tb_ctrace_row_mac;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         init;
  logic [11:0]  config_row, config_col;
  logic [23:0]  config_initial;
  logic         ctrace_valid;
  logic [11:0]  ctrace_row, ctrace_col;
  logic [31:0]  ctrace;
  logic [143:0] fsp;
  logic         flush, sum_ack;
  logic         available, done;
  logic [47:0]  result;
  logic [1:0]   ovf;
  logic [2:0]   n_hits;

  ctrace_row_mac dut (
    .CLK(CLK), .RESET(RESET), .init(init),
    .config_row(config_row), .config_col(config_col), .config_initial(config_initial),
    .ctrace_valid(ctrace_valid), .ctrace_row(ctrace_row), .ctrace_col(ctrace_col),
    .ctrace(ctrace), .fsp(fsp), .flush(flush), .sum_ack(sum_ack),
    .available(available), .done(done), .result(result), .ovf(ovf), .n_hits(n_hits)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [47:0] res;
    logic [1:0]  ovf;
    logic [2:0]  hits;
    int          done_at;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called on the negedge where the terminating input is driven.
  task automatic push_exp(input int g, input int r, input logic [1:0] o, input logic [2:0] h);
    exp_t e;
    e.res     = {24'(r), 24'(g)};
    e.ovf     = o;
    e.hits    = h;
    e.done_at = cyc + 3;
    sb.push_back(e);
  endtask

  initial begin : monitor
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          check("done_latency", 64'(cyc), 64'(e.done_at));
          check("result",       64'(result), 64'(e.res));
          check("ovf",          64'(ovf), 64'(e.ovf));
          check("n_hits",       64'(n_hits), 64'(e.hits));
        end
      end
      done_prev = done;
    end
  end

  task automatic set_weights(input logic [11:0] w);
    for (int k = 0; k < 12; k++) fsp[k*12 +: 12] = w;
  endtask

  task automatic do_init(input logic [11:0] r, input logic [11:0] c, input int initial_val);
    init = 1'b1; config_row = r; config_col = c; config_initial = 24'(initial_val);
    @(negedge CLK);
    init = 1'b0;
  endtask

  task automatic send(input logic [11:0] r, input logic [11:0] c,
                      input logic signed [15:0] g, input logic signed [15:0] rd);
    ctrace_valid = 1'b1; ctrace_row = r; ctrace_col = c; ctrace = {rd, g};
    @(negedge CLK);
    ctrace_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 10 && !done; k++) @(negedge CLK);
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wait_done: done stayed 0 past cycle budget (cycle %0d)", cyc);
    end
  endtask

  task automatic ack();
    sum_ack = 1'b1;
    @(negedge CLK);
    sum_ack = 1'b0;
    check("available_after_ack", 64'(available), 64'(1));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    RESET = 1'b1; init = 1'b0; config_row = '0; config_col = '0; config_initial = '0;
    ctrace_valid = 1'b0; ctrace_row = '0; ctrace_col = '0; ctrace = '0;
    fsp = '0; flush = 1'b0; sum_ack = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_available", 64'(available), 64'(1));
    check("reset_done",      64'(done), 64'(0));
    check("reset_result",    64'(result), 64'(0));
    check("reset_ovf",       64'(ovf), 64'(0));
    check("reset_n_hits",    64'(n_hits), 64'(0));
    RESET = 1'b0;
    @(negedge CLK);

    // Full window: 6 overlap samples, last column terminates.
    set_weights(12'd2048);
    do_init(12'd10, 12'd20, 100);
    for (int c = 15; c < 20; c++) send(12'd9, 12'(c), 16'sd4096, -16'sd4096);
    push_exp(12388, -12188, 2'b00, 3'd6);
    send(12'd9, 12'd20, 16'sd4096, -16'sd4096);
    wait_done();
    ack();

    // No overlap: first sample is already past the window.
    do_init(12'd10, 12'd20, 100);
    push_exp(100, 100, 2'b00, 3'd0);
    send(12'd10, 12'd0, 16'sd5, 16'sd5);
    wait_done();
    ack();

    // Partial window closed by flush.
    set_weights(12'd4095);
    do_init(12'd10, 12'd20, 100);
    send(12'd9, 12'd17, 16'sd1000, 16'sd0);
    send(12'd9, 12'd18, 16'sd1000, 16'sd0);
    push_exp(2098, 100, 2'b00, 3'd2);
    pulse_flush();
    wait_done();
    ack();

    // Positive saturation.
    do_init(12'd10, 12'd20, 8388000);
    push_exp(8388607, 8388000, 2'b01, 3'd1);
    send(12'd9, 12'd20, 16'sd32767, 16'sd0);
    wait_done();
    ack();

    // Negative saturation.
    do_init(12'd10, 12'd20, -8388000);
    push_exp(-8388608, -8388000, 2'b01, 3'd1);
    send(12'd9, 12'd20, -16'sd32768, 16'sd0);
    wait_done();
    ack();

    // Before-window samples ignored, then reset mid-collection.
    do_init(12'd10, 12'd20, 100);
    send(12'd8, 12'd18, 16'sd77, 16'sd77);
    send(12'd9, 12'd16, 16'sd10, 16'sd10);
    send(12'd9, 12'd17, 16'sd10, 16'sd10);
    check("hits_before_reset", 64'(n_hits), 64'(2));
    check("collecting_not_available", 64'(available), 64'(0));
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("midrun_reset_available", 64'(available), 64'(1));
    check("midrun_reset_result",    64'(result), 64'(0));
    check("midrun_reset_n_hits",    64'(n_hits), 64'(0));
    repeat (4) @(negedge CLK);
    check("no_done_after_reset", 64'(done), 64'(0));

    // Handshake: init ignored in DONE, sum_ack frees, new init accepted.
    set_weights(12'd2048);
    do_init(12'd10, 12'd20, 100);
    send(12'd9, 12'd19, 16'sd4096, 16'sd4096);
    push_exp(4196, 4196, 2'b00, 3'd2);
    send(12'd9, 12'd20, 16'sd4096, 16'sd4096);
    wait_done();
    do_init(12'd3, 12'd3, 555);
    check("init_in_done_ignored_done",   64'(done), 64'(1));
    check("init_in_done_ignored_result", 64'(result), {16'b0, 24'(4196), 24'(4196)});
    ack();
    do_init(12'd10, 12'd20, -5);
    check("new_init_accepted", 64'(available), 64'(0));
    push_exp(-5, -5, 2'b00, 3'd0);
    pulse_flush();
    wait_done();
    ack();

    repeat (3) @(negedge CLK);
    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrace_row_mac.md
Name: ctrace_row_mac

Overview:
- Parametrised successor to the per-row camera-trace summer.
- Accumulates the projection of a raster-ordered camera-trace stream through one FSP row, for N_CAM virtual cameras and an arbitrary FSP_WIDTH.
- Uses signed fixed-point multiply-accumulate. Adds a saturation flag, a hit count, an explicit flush, and a deterministic drain latency.
- Sits in the projector array; one instance per FSP row. It is loaded by the pixel scheduler and drained through the result handshake.

Parameters:
DELAY, 1, simulation delay on registered assignments
N_CAM, 2, number of virtual cameras (channels)
FSP_WIDTH, 6, FSP columns per row (window width)
FSP_ROW, 1, row offset of this instance within the FSP
CAM_ROW_SIZE, 12, camera row index width
CAM_COL_SIZE, 12, camera column index width
CT_W, 16, signed camera-trace sample width
FSP_W, 12, unsigned FSP weight width, Q0.FSP_W
ACC_W, 24, signed accumulator/result width

Ports:
CLK  in  1  clock
RESET  in  1  synchronous active-high reset
init  in  1  load config; accepted only in FREE
config_row  in  CAM_ROW_SIZE  target row
config_col  in  CAM_COL_SIZE  target column
config_initial  in  ACC_W  signed accumulator start value
ctrace_valid  in  1  stream sample valid
ctrace_row  in  CAM_ROW_SIZE  sample row
ctrace_col  in  CAM_COL_SIZE  sample column
ctrace  in  N_CAM*CT_W  packed signed samples; cam0 in the LSBs
fsp  in  N_CAM*FSP_WIDTH*FSP_W  packed weights; index [cam][col], col-major within cam
flush  in  1  end of frame; force finish
sum_ack  in  1  consumer took result
available  out  1  state==FREE
done  out  1  state==DONE
result  out  N_CAM*ACC_W  packed sums
ovf  out  N_CAM  sticky per-camera saturation
n_hits  out  clog2(FSP_WIDTH+1)  overlapping samples accumulated

Behaviour:
- Reset:
  - State goes to FREE.
  - result, ovf, n_hits and pipeline valids are cleared to 0.
  - Reset mid-operation discards all work; the next cycle is FREE.
- States: FREE, COLLECTING, FINISHING, DONE.
- FREE:
  - init latches config, loads each accumulator with config_initial, and clears ovf and n_hits.
  - Next state is COLLECTING.
- COLLECTING: samples are classified only when ctrace_valid=1, using pr = ctrace_row+FSP_ROW (mod 2^CAM_ROW_SIZE) and d = me_col-ctrace_col (signed, CAM_COL_SIZE+1 bits).
  - before: pr<me_row, or pr==me_row and d>=FSP_WIDTH. Sample is ignored.
  - overlap: pr==me_row and 0<=d<FSP_WIDTH. Sample is issued to the MAC with weight fsp[cam][d], and n_hits increments (saturating at FSP_WIDTH).
    - If d==0 (last window column), the state goes to FINISHING in the same step.
  - after: pr>me_row, or pr==me_row and d<0. The sample is not accumulated; state goes to FINISHING.
  - flush (any cycle in COLLECTING): state goes to FINISHING. flush takes priority over a simultaneous sample's classification, but a simultaneous overlap sample is still accumulated.
  - Duplicate columns are accumulated each time they appear.
- MAC pipeline, per camera:
  - Stage 1 registers p = (ctrace * {0,fsp}) >>> FSP_W. The product is CT_W+FSP_W+1 bits; the shift is arithmetic (floor).
  - Stage 2 computes acc = sat(acc + sext(p)) to the range [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - On clamp, ovf[cam] is set; it stays set until the next init.
- FINISHING waits for both pipeline stages to empty, then copies the accumulators to result and enters DONE.
- Latency:
  - done rises exactly 3 cycles after the terminating cycle (the d==0 sample, the after sample, or flush).
  - An overlap sample issued at cycle t is reflected in the accumulator at t+2.
- DONE:
  - result, ovf and n_hits are held stable.
  - sum_ack takes the state to FREE next cycle.
  - init is ignored in DONE and FINISHING. ctrace_valid is ignored outside COLLECTING.
- result retains its value until the next DONE or RESET.
- Zero hits: result = config_initial, with the same 3-cycle latency.

Test Plan:
- Full window: N_CAM=2, FSP_W=12. init row=10, col=20, initial=100. Send samples at row 9, cols 15..20, with grn=4096 and red=-4096, all weights 2048.
  - Required: done 3 cycles after col 20; grn=12388, red=-12188, n_hits=6, ovf=0.
- No overlap: same init; first sample at row 10, col 0 (after).
  - Required: done 3 cycles later; result=100 both; n_hits=0.
- Partial + flush: samples at row 9, cols 17..18 with grn=1000 and weight 4095, then flush.
  - Required: grn=100+999+999=2098; n_hits=2; done flush+3.
- Saturation: initial=8388000, one overlap sample with grn=32767 and weight 4095 (product 32759).
  - Required: grn=8388607, ovf[0]=1.
  - Negative case: initial=-8388000, grn=-32768, weight 4095 (product -32760). Required: result=-8388608.
- Before-window + reset: row 8 samples are ignored. Assert RESET during COLLECTING after 2 hits.
  - Required: available=1 next cycle; result=0, n_hits=0.
- Handshake: init pulsed during DONE is ignored (result unchanged). sum_ack gives available=1 next cycle; a new init is accepted.
